m_stage_lsu: RTL and testbench

Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage. It holds the E/M pipeline register and performs load/store accesses over a req/ack data bus with wait states and a timeout. It detects address exceptions and produces aligned, extended load data for write-back. It stalls the upstream pipeline while a bus transaction is outstanding.

---
 rtl/m_stage_lsu_if.sv | 37 +++
 rtl/m_stage_lsu.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_m_stage_lsu.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_stage_lsu_if.sv
// Data-bus bundle between the memory stage (master) and data memory (slave).
//
// Handshake: the master raises bus_req_o together with bus_we_o, bus_addr_o,
// bus_be_o and bus_wdata_o, and holds all of them stable for as long as
// bus_req_o is high. The slave completes the transfer with a single-cycle
// bus_ack_i; bus_rdata_i is only meaningful in that ack cycle. The master may
// withdraw a request without an ack (timeout abort or reset), so the slave must
// not assume that every request it sees will be completed.
interface m_stage_lsu_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    modport master (
        output bus_req_o,
        output bus_we_o,
        output bus_addr_o,
        output bus_be_o,
        output bus_wdata_o,
        input  bus_ack_i,
        input  bus_rdata_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_we_o,
        input  bus_addr_o,
        input  bus_be_o,
        input  bus_wdata_o,
        output bus_ack_i,
        output bus_rdata_i
    );
endinterface

// File: rtl/m_stage_lsu.sv
// Memory stage of the 5-stage MIPS pipeline. Holds the E/M pipeline register,
// screens loads/stores for address exceptions, runs one req/ack data-bus
// transfer per legal memory op (with a wait-state timeout), and produces the
// aligned, extended load result for write-back. The upstream stages are frozen
// while a transfer is outstanding.
module m_stage_lsu #(
    parameter logic [31:0] DM_BASE     = 32'h0000_0000,
    parameter logic [31:0] DM_LIMIT    = 32'h0000_2FFF,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic [31:0]   Instr_E_I,
    input  logic [31:0]   PC_E_I,
    input  logic [31:0]   ALURS_E_I,
    input  logic [31:0]   WD_E_I,
    input  logic          RFWr_E_I,
    input  logic [4:0]    DstE_E_I,
    input  logic [8:2]    ExCode_E_I,
    m_stage_lsu_if.master bus,
    output logic [31:0]   Instr_M_O,
    output logic [31:0]   PC_M_O,
    output logic [31:0]   ALURS_M_O,
    output logic          RFWr_M_O,
    output logic [4:0]    DstM_M_O,
    output logic [31:0]   RD_M_O,
    output logic [8:2]    ExCode_M_O,
    output logic          Stall_M_O,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    typedef struct packed {
        logic  ld;
        logic  st;
        size_e size;
        logic  sext;
    } mem_op_t;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    // Counter value seen in the last ACCESS cycle allowed before abort.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    function automatic mem_op_t decode_op(input logic [5:0] opc);
        mem_op_t d;
        d = '{ld: 1'b0, st: 1'b0, size: SZ_NONE, sext: 1'b0};
        case (opc)
            OP_LB:   d = '{ld: 1'b1, st: 1'b0, size: SZ_BYTE, sext: 1'b1};
            OP_LBU:  d = '{ld: 1'b1, st: 1'b0, size: SZ_BYTE, sext: 1'b0};
            OP_LH:   d = '{ld: 1'b1, st: 1'b0, size: SZ_HALF, sext: 1'b1};
            OP_LHU:  d = '{ld: 1'b1, st: 1'b0, size: SZ_HALF, sext: 1'b0};
            OP_LW:   d = '{ld: 1'b1, st: 1'b0, size: SZ_WORD, sext: 1'b0};
            OP_SB:   d = '{ld: 1'b0, st: 1'b1, size: SZ_BYTE, sext: 1'b0};
            OP_SH:   d = '{ld: 1'b0, st: 1'b1, size: SZ_HALF, sext: 1'b0};
            OP_SW:   d = '{ld: 1'b0, st: 1'b1, size: SZ_WORD, sext: 1'b0};
            default: ;
        endcase
        return d;
    endfunction

    // ------------------------------------------------------------------
    // E-side screening: decode, address checks, final exception code
    // ------------------------------------------------------------------
    mem_op_t    e_op;
    logic       e_is_mem;
    logic       e_misalign;
    logic       e_out_of_range;
    logic       e_addr_exc;
    logic       e_start;
    logic [8:2] e_excode;

    // Classify the incoming op and decide whether it may touch the bus.
    always_comb begin
        e_op       = decode_op(Instr_E_I[31:26]);
        e_is_mem   = e_op.ld | e_op.st;
        e_misalign = ((e_op.size == SZ_WORD) && (ALURS_E_I[1:0] != 2'b00)) ||
                     ((e_op.size == SZ_HALF) && ALURS_E_I[0]);
        // Offsetting by the base folds both bounds into one unsigned compare:
        // addresses below the base wrap to huge values.
        e_out_of_range = (ALURS_E_I - DM_BASE) > (DM_LIMIT - DM_BASE);
        // An exception already raised upstream has priority and is untouched.
        e_addr_exc = e_is_mem && !ExCode_E_I[7] && (e_misalign || e_out_of_range);
        e_excode   = ExCode_E_I;
        if (e_addr_exc) begin
            e_excode = {ExCode_E_I[8], 1'b1, e_op.st ? EXC_ADES : EXC_ADEL};
        end
        e_start = e_is_mem && !ExCode_E_I[7] && !e_addr_exc && !flush_i;
    end

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------
    state_e     state_q;
    state_e     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       ack_hit;
    logic       timeout_hit;
    logic       access;
    logic       advance;

    assign access  = (state_q == ST_ACCESS);
    assign advance = !access;

    // State and wait-cycle counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: start on a legal op, finish on ack, abort on timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                cnt_d   = '0;
                state_d = e_start ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                // Ack is tested first so it wins over a same-cycle timeout.
                if (bus.bus_ack_i) begin
                    ack_hit = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // E/M pipeline register
    // ------------------------------------------------------------------
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] alurs_q;
    logic [31:0] wd_q;
    logic [31:0] rdata_q;
    logic        rfwr_q;
    logic [4:0]  dst_q;
    logic [8:2]  excode_q;
    mem_op_t     m_op_q;

    // Load from E when not stalled; otherwise capture read data or a bus error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_q  <= '0;
            pc_q     <= '0;
            alurs_q  <= '0;
            wd_q     <= '0;
            rdata_q  <= '0;
            rfwr_q   <= 1'b0;
            dst_q    <= '0;
            excode_q <= '0;
            m_op_q   <= '0;
        end else if (advance) begin
            rdata_q <= '0;
            if (flush_i) begin
                instr_q  <= '0;
                pc_q     <= '0;
                alurs_q  <= '0;
                wd_q     <= '0;
                rfwr_q   <= 1'b0;
                dst_q    <= '0;
                excode_q <= '0;
                m_op_q   <= '0;
            end else begin
                instr_q  <= Instr_E_I;
                pc_q     <= PC_E_I;
                alurs_q  <= ALURS_E_I;
                wd_q     <= WD_E_I;
                rfwr_q   <= RFWr_E_I;
                dst_q    <= DstE_E_I;
                excode_q <= e_excode;
                m_op_q   <= e_op;
            end
        end else begin
            if (ack_hit) begin
                rdata_q <= bus.bus_rdata_i;
            end
            if (timeout_hit) begin
                excode_q <= {excode_q[8], 1'b1, EXC_DBE};
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus drive: everything derives from the held E/M register, so it stays
    // stable for the whole ACCESS period and is quiet outside it.
    // ------------------------------------------------------------------
    // Byte enables and lane-replicated store data for the current op.
    always_comb begin
        bus.bus_req_o   = access;
        bus.bus_we_o    = access & m_op_q.st;
        bus.bus_addr_o  = access ? {alurs_q[31:2], 2'b00} : 32'd0;
        bus.bus_be_o    = 4'b0000;
        bus.bus_wdata_o = 32'd0;
        if (access) begin
            case (m_op_q.size)
                SZ_BYTE: begin
                    bus.bus_be_o    = 4'b0001 << alurs_q[1:0];
                    bus.bus_wdata_o = {4{wd_q[7:0]}};
                end
                SZ_HALF: begin
                    bus.bus_be_o    = alurs_q[1] ? 4'b1100 : 4'b0011;
                    bus.bus_wdata_o = {2{wd_q[15:0]}};
                end
                SZ_WORD: begin
                    bus.bus_be_o    = 4'b1111;
                    bus.bus_wdata_o = wd_q;
                end
                default: ;
            endcase
            if (!m_op_q.st) begin
                bus.bus_wdata_o = 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load data alignment and extension (little-endian lanes)
    // ------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Select the addressed lane and extend it; zero for anything but a clean load.
    always_comb begin
        case (alurs_q[1:0])
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = alurs_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        RD_M_O  = 32'd0;
        if (m_op_q.ld && !excode_q[7]) begin
            case (m_op_q.size)
                SZ_BYTE: RD_M_O = {{24{m_op_q.sext & ld_byte[7]}}, ld_byte};
                SZ_HALF: RD_M_O = {{16{m_op_q.sext & ld_half[15]}}, ld_half};
                SZ_WORD: RD_M_O = rdata_q;
                default: RD_M_O = 32'd0;
            endcase
        end
    end

    assign Instr_M_O   = instr_q;
    assign PC_M_O      = pc_q;
    assign ALURS_M_O   = alurs_q;
    assign RFWr_M_O    = rfwr_q & ~excode_q[7];
    assign DstM_M_O    = dst_q;
    assign ExCode_M_O  = excode_q;
    assign Stall_M_O   = access;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_m_stage_lsu.sv
// Self-checking bench for m_stage_lsu: directed cases followed by random
// memory/non-memory ops, each checked against a transaction-level model of the
// memory stage (address rules, lane arithmetic, wait/timeout count).
module tb_m_stage_lsu;

    localparam logic [31:0] TB_DM_BASE  = 32'h0000_0000;
    localparam logic [31:0] TB_DM_LIMIT = 32'h0000_2FFF;
    localparam int          TB_TIMEOUT  = 4;
    localparam int          MAX_WAIT    = 20;
    localparam int          N_RANDOM    = 300;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic [31:0] Instr_E_I;
    logic [31:0] PC_E_I;
    logic [31:0] ALURS_E_I;
    logic [31:0] WD_E_I;
    logic        RFWr_E_I;
    logic [4:0]  DstE_E_I;
    logic [8:2]  ExCode_E_I;
    logic [31:0] Instr_M_O;
    logic [31:0] PC_M_O;
    logic [31:0] ALURS_M_O;
    logic        RFWr_M_O;
    logic [4:0]  DstM_M_O;
    logic [31:0] RD_M_O;
    logic [8:2]  ExCode_M_O;
    logic        Stall_M_O;
    logic [1:0]  dbg_state_o;

    m_stage_lsu_if bus();

    m_stage_lsu #(
        .DM_BASE     (TB_DM_BASE),
        .DM_LIMIT    (TB_DM_LIMIT),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush_i),
        .Instr_E_I   (Instr_E_I),
        .PC_E_I      (PC_E_I),
        .ALURS_E_I   (ALURS_E_I),
        .WD_E_I      (WD_E_I),
        .RFWr_E_I    (RFWr_E_I),
        .DstE_E_I    (DstE_E_I),
        .ExCode_E_I  (ExCode_E_I),
        .bus         (bus),
        .Instr_M_O   (Instr_M_O),
        .PC_M_O      (PC_M_O),
        .ALURS_M_O   (ALURS_M_O),
        .RFWr_M_O    (RFWr_M_O),
        .DstM_M_O    (DstM_M_O),
        .RD_M_O      (RD_M_O),
        .ExCode_M_O  (ExCode_M_O),
        .Stall_M_O   (Stall_M_O),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_bus_req"},   32'(bus.bus_req_o),   32'd0);
        check_eq({pfx, "_bus_we"},    32'(bus.bus_we_o),    32'd0);
        check_eq({pfx, "_bus_addr"},  bus.bus_addr_o,       32'd0);
        check_eq({pfx, "_bus_be"},    32'(bus.bus_be_o),    32'd0);
        check_eq({pfx, "_bus_wdata"}, bus.bus_wdata_o,      32'd0);
        check_eq({pfx, "_instr"},     Instr_M_O,            32'd0);
        check_eq({pfx, "_pc"},        PC_M_O,               32'd0);
        check_eq({pfx, "_alurs"},     ALURS_M_O,            32'd0);
        check_eq({pfx, "_rfwr"},      32'(RFWr_M_O),        32'd0);
        check_eq({pfx, "_dst"},       32'(DstM_M_O),        32'd0);
        check_eq({pfx, "_rd"},        RD_M_O,               32'd0);
        check_eq({pfx, "_excode"},    32'(ExCode_M_O),      32'd0);
        check_eq({pfx, "_stall"},     32'(Stall_M_O),       32'd0);
    endtask

    // ---------------- reference model ----------------
    // Access width in bytes (0 = not a memory op), load/store, signedness.
    function automatic void ref_decode(input logic [5:0] opc, output int nbytes,
                                       output bit is_load, output bit is_signed);
        nbytes    = 0;
        is_load   = 1'b0;
        is_signed = 1'b0;
        case (opc)
            6'h23: begin nbytes = 4; is_load = 1'b1; end
            6'h21: begin nbytes = 2; is_load = 1'b1; is_signed = 1'b1; end
            6'h25: begin nbytes = 2; is_load = 1'b1; end
            6'h20: begin nbytes = 1; is_load = 1'b1; is_signed = 1'b1; end
            6'h24: begin nbytes = 1; is_load = 1'b1; end
            6'h2B: nbytes = 4;
            6'h29: nbytes = 2;
            6'h28: nbytes = 1;
            default: ;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Issue one op from E at a non-stalled negedge, act as the bus slave
    // (ack in the ack_n-th request cycle), then check the completed M state.
    task automatic run_op(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] wd,
                          input logic rfwr, input logic [8:2] exc_in, input bit flush,
                          input int ack_n, input logic [31:0] rdata);
        int          nbytes;
        bit          is_load;
        bit          is_signed;
        int          off;
        longint      a;
        longint      lo;
        longint      hi;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [8:2]  exc_exp;
        int          cyc_exp;
        logic [3:0]  be_exp;
        logic [31:0] wdata_exp;
        logic [31:0] rd_exp;
        logic        rfwr_exp;
        logic [63:0] v;
        int          cyc;

        instr = {opc, 26'($urandom)};
        pc    = $urandom;
        dst   = 5'($urandom);
        ref_decode(opc, nbytes, is_load, is_signed);
        a   = {32'd0, addr};
        lo  = {32'd0, TB_DM_BASE};
        hi  = {32'd0, TB_DM_LIMIT};
        off = int'(a % 4);

        exc_exp = exc_in;
        cyc_exp = 0;
        if (nbytes != 0 && !exc_in[7]) begin
            if ((a % nbytes) != 0 || a < lo || a > hi) begin
                exc_exp = {exc_in[8], 1'b1, is_load ? 5'd4 : 5'd5};
            end else if (ack_n <= TB_TIMEOUT) begin
                cyc_exp = ack_n;
            end else begin
                cyc_exp = TB_TIMEOUT;
                exc_exp = {exc_in[8], 1'b1, 5'd7};
            end
        end

        be_exp = 4'(((1 << nbytes) - 1) << off);
        if (nbytes == 1)      wdata_exp = (wd & 32'h0000_00FF) * 32'h0101_0101;
        else if (nbytes == 2) wdata_exp = (wd & 32'h0000_FFFF) * 32'h0001_0001;
        else                  wdata_exp = wd;

        rd_exp = 32'd0;
        if (is_load && !exc_exp[7]) begin
            v = ({32'd0, rdata} >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 64'd1);
            if (is_signed && v >= (64'd1 << (8 * nbytes - 1))) begin
                v = v - (64'd1 << (8 * nbytes));
            end
            rd_exp = v[31:0];
        end
        rfwr_exp = rfwr & ~exc_exp[7];

        if (flush) begin
            exc_exp  = '0;
            cyc_exp  = 0;
            rd_exp   = 32'd0;
            rfwr_exp = 1'b0;
        end
        exp_q.push_back(rd_exp);

        Instr_E_I  = instr;
        PC_E_I     = pc;
        ALURS_E_I  = addr;
        WD_E_I     = wd;
        RFWr_E_I   = rfwr;
        DstE_E_I   = dst;
        ExCode_E_I = exc_in;
        flush_i    = flush;
        check_eq("stall_before_issue", 32'(Stall_M_O), 32'd0);
        @(posedge clk);
        @(negedge clk);

        // Garbage on the E side (including flush) must not disturb a held op.
        Instr_E_I  = $urandom;
        PC_E_I     = $urandom;
        ALURS_E_I  = $urandom;
        WD_E_I     = $urandom;
        RFWr_E_I   = 1'($urandom);
        DstE_E_I   = 5'($urandom);
        ExCode_E_I = 7'($urandom);
        flush_i    = 1'($urandom);

        cyc = 0;
        while (bus.bus_req_o === 1'b1 && cyc < MAX_WAIT) begin
            cyc++;
            check_eq("stall_in_access", 32'(Stall_M_O), 32'd1);
            check_eq("bus_we", 32'(bus.bus_we_o), is_load ? 32'd0 : 32'd1);
            check_eq("bus_addr", bus.bus_addr_o, addr & 32'hFFFF_FFFC);
            check_eq("bus_be", 32'(bus.bus_be_o), 32'(be_exp));
            if (!is_load) check_eq("bus_wdata", bus.bus_wdata_o, wdata_exp);
            if (cyc == ack_n) begin
                bus.bus_ack_i   = 1'b1;
                bus.bus_rdata_i = rdata;
            end
            @(posedge clk);
            @(negedge clk);
            bus.bus_ack_i   = 1'b0;
            bus.bus_rdata_i = $urandom;
        end

        check_eq("access_cycles", 32'(cyc), 32'(cyc_exp));
        check_eq("stall_done", 32'(Stall_M_O), 32'd0);
        check_eq("instr_m", Instr_M_O, flush ? 32'd0 : instr);
        check_eq("pc_m", PC_M_O, flush ? 32'd0 : pc);
        check_eq("alurs_m", ALURS_M_O, flush ? 32'd0 : addr);
        check_eq("dst_m", 32'(DstM_M_O), flush ? 32'd0 : 32'(dst));
        check_eq("rfwr_m", 32'(RFWr_M_O), 32'(rfwr_exp));
        check_eq("excode_m", 32'(ExCode_M_O), 32'(exc_exp));
        check_eq("rd_m", RD_M_O, exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] opc_tab[10] = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24,
                                6'h2B, 6'h29, 6'h28, 6'h00, 6'h08};

    initial begin
        logic [5:0]  opc;
        logic [31:0] addr;
        logic [8:2]  exc_in;
        int          sel;

        reset           = 1'b0;
        flush_i         = 1'b0;
        Instr_E_I       = '0;
        PC_E_I          = '0;
        ALURS_E_I       = '0;
        WD_E_I          = '0;
        RFWr_E_I        = 1'b0;
        DstE_E_I        = '0;
        ExCode_E_I      = '0;
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Directed cases.
        run_op(6'h23, 32'h0000_0010, $urandom, 1'b1, 7'd0, 1'b0, 3, 32'hDEAD_BEEF);   // lw, 3 waits
        run_op(6'h20, 32'h0000_0013, $urandom, 1'b1, 7'd0, 1'b0, 1, 32'h80FF_1234);   // lb
        run_op(6'h24, 32'h0000_0013, $urandom, 1'b1, 7'd0, 1'b0, 2, 32'h80FF_1234);   // lbu
        run_op(6'h21, 32'h0000_0012, $urandom, 1'b1, 7'd0, 1'b0, 1, 32'h8000_1234);   // lh
        run_op(6'h28, 32'h0000_0021, 32'h0000_00A5, 1'b0, 7'd0, 1'b0, 1, $urandom);   // sb
        run_op(6'h29, 32'h0000_0022, 32'h0000_1234, 1'b0, 7'd0, 1'b0, 1, $urandom);   // sh
        run_op(6'h23, 32'h0000_0006, $urandom, 1'b1, 7'd0, 1'b0, 1, $urandom);        // lw misaligned
        run_op(6'h2B, 32'h0000_3000, $urandom, 1'b0, 7'd0, 1'b0, 1, $urandom);        // sw out of range
        run_op(6'h2B, 32'h0000_0040, $urandom, 1'b0, {1'b0, 1'b1, 5'd12}, 1'b0, 1, $urandom);
        run_op(6'h23, 32'h0000_0010, $urandom, 1'b1, 7'd0, 1'b1, 1, $urandom);        // flushed
        run_op(6'h23, 32'h0000_0020, $urandom, 1'b1, 7'd0, 1'b0, 100, $urandom);      // timeout
        run_op(6'h23, 32'h0000_0024, $urandom, 1'b1, 7'd0, 1'b0, TB_TIMEOUT, 32'h1357_9BDF);
        run_op(6'h21, 32'h0000_0011, $urandom, 1'b1, {1'b1, 1'b0, 5'd0}, 1'b0, 1, $urandom);
        run_op(6'h2B, 32'h0000_2FFC, 32'hCAFE_F00D, 1'b0, 7'd0, 1'b0, 2, $urandom);   // top word

        // Random ops.
        for (int i = 0; i < N_RANDOM; i++) begin
            opc = opc_tab[$urandom_range(0, 9)];
            sel = $urandom_range(0, 9);
            addr = $urandom_range(0, 32'h2FFF);
            if (sel < 4)       addr = addr & 32'hFFFF_FFFC;
            else if (sel < 6)  addr = addr & 32'hFFFF_FFFE;
            else if (sel == 8) addr = 32'h0000_3000 + $urandom_range(0, 255);
            else if (sel == 9) addr = $urandom;
            if ($urandom_range(0, 9) == 0) exc_in = {1'($urandom), 1'b1, 5'($urandom)};
            else                           exc_in = {1'($urandom), 1'b0, 5'($urandom)};
            run_op(opc, addr, $urandom, 1'($urandom), exc_in,
                   ($urandom_range(0, 9) == 0), $urandom_range(1, 6), $urandom);
        end

        // Reset during the second ACCESS cycle of a never-acked load.
        Instr_E_I  = {6'h23, 26'd0};
        PC_E_I     = 32'h0000_0100;
        ALURS_E_I  = 32'h0000_0040;
        WD_E_I     = '0;
        RFWr_E_I   = 1'b1;
        DstE_E_I   = 5'd3;
        ExCode_E_I = '0;
        flush_i    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_mid_req1", 32'(bus.bus_req_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_mid_req2", 32'(bus.bus_req_o), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_mid");
        Instr_E_I = '0;
        RFWr_E_I  = 1'b0;
        DstE_E_I  = '0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("after_rst_stall", 32'(Stall_M_O), 32'd0);

        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
